debug_event_packer: RTL



---
 rtl/debug_pkg.sv | 28 ++
 rtl/debug_event_packer_if.sv | 11 +
 rtl/debug_event_fifo.sv | 48 ++++
 rtl/debug_event_packer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants for the debug event packer: record layout, FSM encoding, drop limit.
package debug_pkg;

    localparam int TS_W         = 16;
    localparam int REC_W        = 1 + 4 + TS_W;
    localparam int REC_TS_LSB   = 0;
    localparam int REC_DATA_LSB = REC_TS_LSB + TS_W;
    localparam int REC_LOST     = REC_DATA_LSB + 4;
    localparam int MARKER_BIT   = 7;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_B0   = 2'd1;
    localparam logic [1:0] ST_B1   = 2'd2;
    localparam logic [1:0] ST_B2   = 2'd3;

    // First byte of a record: marker, lost flag, two zero bits, data nibble.
    function automatic logic [7:0] rec_byte0(input logic lost, input logic [3:0] d);
        logic [7:0] b;
        b             = 8'h00;
        b[MARKER_BIT] = 1'b1;
        b[6]          = lost;
        b[3:0]        = d;
        return b;
    endfunction

endpackage

// File: rtl/debug_event_packer_if.sv
// Valid/ready byte stream carrying packed debug records towards the TX framer.
interface debug_event_packer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/debug_event_fifo.sv
// Single-clock record FIFO; pointers carry one extra wrap bit to tell full from empty.
module debug_event_fifo
    import debug_pkg::*;
#(
    parameter int WIDTH = REC_W,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_wr;
    logic w_do_rd;

    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_wr = wr_en && !full;
    assign w_do_rd = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/debug_event_packer.sv
// Timestamps debug change events, queues them and emits each as a 3-byte record
// on a valid/ready byte stream, tracking events lost to FIFO overflow.
module debug_event_packer
    import debug_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trigger,
    input  logic [DATA_W-1:0]  data,
    debug_event_packer_if.master tx,
    output logic               overflow,
    output logic [7:0]         drop_count,
    input  logic               clear_overflow
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

    logic [TS_W-1:0]  r_ts;
    logic             r_lost_pending;
    logic             r_overflow;
    logic [7:0]       r_drop_count;
    logic [1:0]       r_state;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;
    logic [15:0]      r_hold_ts;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_drop;
    logic             w_hs;
    logic             w_pop;
    logic [REC_W-1:0] w_wr_data;
    logic [REC_W-1:0] w_rd_data;
    logic [7:0]       w_rd_byte0;

    // Full is the registered pointer state, so a same-edge pop never frees a slot.
    assign w_wr_en    = trigger && !w_full;
    assign w_drop     = trigger && w_full;
    assign w_wr_data  = {r_lost_pending, 4'(data), r_ts};
    assign w_hs       = r_tx_valid && tx.tx_ready;
    assign w_pop      = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_B2) && w_hs));
    assign w_rd_byte0 = rec_byte0(w_rd_data[REC_LOST], w_rd_data[REC_DATA_LSB +: 4]);

    debug_event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ts <= '0;
        else          r_ts <= r_ts + TS_W'(1);
    end

    // A drop on the same edge as a clear leaves exactly that one drop recorded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lost_pending <= 1'b0;
            r_overflow     <= 1'b0;
            r_drop_count   <= 8'd0;
        end else if (w_drop) begin
            r_lost_pending <= 1'b1;
            r_overflow     <= 1'b1;
            r_drop_count   <= clear_overflow ? 8'd1 : sat_inc(r_drop_count);
        end else begin
            if (w_wr_en) r_lost_pending <= 1'b0;
            if (clear_overflow) begin
                r_overflow   <= 1'b0;
                r_drop_count <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state    <= ST_B0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_rd_byte0;
                    end
                end
                ST_B0: begin
                    if (w_hs) begin
                        r_state   <= ST_B1;
                        r_tx_data <= r_hold_ts[15:8];
                    end
                end
                ST_B1: begin
                    if (w_hs) begin
                        r_state   <= ST_B2;
                        r_tx_data <= r_hold_ts[7:0];
                    end
                end
                default: begin
                    if (w_hs) begin
                        if (w_pop) begin
                            r_state   <= ST_B0;
                            r_tx_data <= w_rd_byte0;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) r_hold_ts <= w_rd_data[REC_TS_LSB +: 16];
    end

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;

endmodule
